// File: rtl/input_pingpong_buffer_if.sv
// Handshake bundle for input_pingpong_buffer.
// master: producer/consumer side; slave: the buffer itself.
interface input_pingpong_buffer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int LANES      = 4
);
  localparam int W = LANES * DATA_WIDTH;

  logic                  wr_valid;
  logic [W-1:0]          wr_data;
  logic                  wr_last;
  logic                  wr_ready;
  logic                  wr_drop;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [W-1:0]          rd_data;
  logic                  rd_valid;
  logic                  rd_release;
  logic                  rd_ready;
  logic [ADDR_WIDTH:0]   rd_count;

  modport master (
    output wr_valid, wr_data, wr_last, rd_en, rd_addr, rd_release,
    input  wr_ready, wr_drop, rd_data, rd_valid, rd_ready, rd_count
  );

  modport slave (
    input  wr_valid, wr_data, wr_last, rd_en, rd_addr, rd_release,
    output wr_ready, wr_drop, rd_data, rd_valid, rd_ready, rd_count
  );
endinterface

// File: rtl/input_pingpong_buffer.sv
// Double-banked (ping-pong) input staging buffer.
// A producer streams words into the write bank while the consumer randomly
// reads the other bank; ownership moves via commit (wr_last / auto) and release.
// Optional feature: define INBUF_ZERO_PAD_EN to return zeros for reads at or
// beyond the committed word count of the read bank.
module input_pingpong_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int LANES      = 4
) (
  input logic                  clk,
  input logic                  rst,
  input_pingpong_buffer_if.slave bus
);
  localparam int W     = LANES * DATA_WIDTH;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_FILL,
    ST_FULL
  } bank_state_t;

  bank_state_t           r_state [2];
  logic [ADDR_WIDTH:0]   r_cnt   [2];
  logic                  r_wb;
  logic                  r_rb;
  logic [ADDR_WIDTH-1:0] r_wptr;
  logic [W-1:0]          r_rd_data;
  logic                  r_rd_valid;
  logic                  r_wr_drop;

  // Both banks live in one array; the bank pointer is the address MSB.
  logic [W-1:0]          r_mem [2*DEPTH];

  logic                  w_wr_ready;
  logic                  w_rd_ready;
  logic [ADDR_WIDTH:0]   w_rd_count;
  logic                  w_wr_acc;
  logic                  w_commit;
  logic                  w_rd_acc;
  logic                  w_release;
  logic                  w_pad;

  // Handshake qualifiers, derived only from registered bank state
  always_comb begin
    w_wr_ready = (r_state[r_wb] != ST_FULL);
    w_rd_ready = (r_state[r_rb] == ST_FULL);
    w_rd_count = w_rd_ready ? r_cnt[r_rb] : '0;
    w_wr_acc   = bus.wr_valid & w_wr_ready;
    w_commit   = w_wr_acc & (bus.wr_last | (&r_wptr));
    w_rd_acc   = bus.rd_en & w_rd_ready;
    w_release  = bus.rd_release & w_rd_ready;
`ifdef INBUF_ZERO_PAD_EN
    w_pad      = ({1'b0, bus.rd_addr} >= w_rd_count);
`else
    w_pad      = 1'b0;
`endif
  end

  assign bus.wr_ready = w_wr_ready;
  assign bus.rd_ready = w_rd_ready;
  assign bus.rd_count = w_rd_count;
  assign bus.rd_data  = r_rd_data;
  assign bus.rd_valid = r_rd_valid;
  assign bus.wr_drop  = r_wr_drop;

  // Storage write port; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (w_wr_acc && !rst) begin
      r_mem[{r_wb, r_wptr}] <= bus.wr_data;
    end
  end

  // Bank ownership FSM, write pointer, read port and sticky drop flag.
  // Commit and release never qualify on the same bank (FULL vs not FULL),
  // so their per-bank updates cannot collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned b = 0; b < 2; b++) begin
        r_state[b] <= ST_EMPTY;
        r_cnt[b]   <= '0;
      end
      r_wb       <= 1'b0;
      r_rb       <= 1'b0;
      r_wptr     <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_wr_drop  <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_cnt[r_wb] <= {1'b0, r_wptr} + (ADDR_WIDTH+1)'(1);
        if (w_commit) begin
          r_state[r_wb] <= ST_FULL;
          r_wb          <= ~r_wb;
          r_wptr        <= '0;
        end else begin
          r_state[r_wb] <= ST_FILL;
          r_wptr        <= r_wptr + ADDR_WIDTH'(1);
        end
      end else if (bus.wr_valid) begin
        r_wr_drop <= 1'b1;
      end

      if (w_release) begin
        r_state[r_rb] <= ST_EMPTY;
        r_cnt[r_rb]   <= '0;
        r_rb          <= ~r_rb;
      end

      if (w_rd_acc) begin
        r_rd_valid <= 1'b1;
        r_rd_data  <= w_pad ? '0 : r_mem[{r_rb, bus.rd_addr}];
      end else begin
        r_rd_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_input_pingpong_buffer.sv
// Directed, table-driven bench for input_pingpong_buffer (DEPTH = 8, W = 32).
module tb_input_pingpong_buffer;
  localparam int DW = 8;
  localparam int AW = 3;
  localparam int LN = 4;

`ifdef INBUF_ZERO_PAD_EN
  localparam logic [31:0] PAD_EXP = 32'h0;
`else
  localparam logic [31:0] PAD_EXP = 32'h55;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  input_pingpong_buffer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LANES(LN)) bus ();

  input_pingpong_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LANES(LN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        wv;
    logic [31:0] wd;
    logic        wl;
    logic        re;
    logic [2:0]  ra;
    logic        rr;
    logic        e_wrdy;
    logic        e_drop;
    logic        e_rrdy;
    logic [3:0]  e_cnt;
    logic        e_rv;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic add(input logic wv, input logic [31:0] wd, input logic wl,
                     input logic re, input logic [2:0] ra, input logic rr,
                     input logic e_wrdy, input logic e_drop, input logic e_rrdy,
                     input logic [3:0] e_cnt, input logic e_rv, input logic [31:0] e_rd);
    vec_t v;
    v.wv = wv; v.wd = wd; v.wl = wl; v.re = re; v.ra = ra; v.rr = rr;
    v.e_wrdy = e_wrdy; v.e_drop = e_drop; v.e_rrdy = e_rrdy;
    v.e_cnt = e_cnt; v.e_rv = e_rv; v.e_rd = e_rd;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wv, input logic [31:0] wd, input logic wl,
                       input logic re, input logic [2:0] ra, input logic rr);
    bus.wr_valid = wv; bus.wr_data = wd; bus.wr_last = wl;
    bus.rd_en = re; bus.rd_addr = ra; bus.rd_release = rr;
  endtask

  task automatic chk_all(input string tag, input logic e_wrdy, input logic e_drop,
                         input logic e_rrdy, input logic [3:0] e_cnt,
                         input logic e_rv, input logic [31:0] e_rd);
    chk({tag, ".wr_ready"}, 32'(bus.wr_ready), 32'(e_wrdy));
    chk({tag, ".wr_drop"},  32'(bus.wr_drop),  32'(e_drop));
    chk({tag, ".rd_ready"}, 32'(bus.rd_ready), 32'(e_rrdy));
    chk({tag, ".rd_count"}, 32'(bus.rd_count), 32'(e_cnt));
    chk({tag, ".rd_valid"}, 32'(bus.rd_valid), 32'(e_rv));
    chk({tag, ".rd_data"},  bus.rd_data,       e_rd);
  endtask

  initial begin
    //   wv  wd     wl re ra rr | wrdy drop rrdy cnt rv rd
    // 3-word tile into bank0, then reads overlapping an 8-word fill of bank1
    add(1, 32'h0A, 0, 0, 0, 0,  1, 0, 0, 0, 0, 32'h00);
    add(1, 32'h0B, 0, 0, 0, 0,  1, 0, 0, 0, 0, 32'h00);
    add(1, 32'h0C, 1, 0, 0, 0,  1, 0, 1, 3, 0, 32'h00);
    add(1, 32'h10, 0, 1, 0, 0,  1, 0, 1, 3, 1, 32'h0A);
    add(1, 32'h11, 0, 1, 1, 0,  1, 0, 1, 3, 1, 32'h0B);
    add(1, 32'h12, 0, 1, 2, 0,  1, 0, 1, 3, 1, 32'h0C);
    add(1, 32'h13, 0, 1, 0, 0,  1, 0, 1, 3, 1, 32'h0A);
    add(1, 32'h14, 0, 0, 0, 0,  1, 0, 1, 3, 0, 32'h0A);
    add(1, 32'h15, 0, 1, 2, 0,  1, 0, 1, 3, 1, 32'h0C);
    add(1, 32'h16, 0, 1, 1, 0,  1, 0, 1, 3, 1, 32'h0B);
    add(1, 32'h17, 1, 0, 0, 0,  0, 0, 1, 3, 0, 32'h0B);
    // read + release in the same cycle reads the old bank
    add(0, 32'h00, 0, 1, 0, 1,  1, 0, 1, 8, 1, 32'h0A);
    add(0, 32'h00, 0, 1, 0, 0,  1, 0, 1, 8, 1, 32'h10);
    add(0, 32'h00, 0, 1, 7, 0,  1, 0, 1, 8, 1, 32'h17);
    add(0, 32'h00, 0, 1, 3, 0,  1, 0, 1, 8, 1, 32'h13);
    add(0, 32'h00, 0, 0, 0, 1,  1, 0, 0, 0, 0, 32'h13);
    // full stall: commit two 4-word tiles, then attempt a write
    add(1, 32'h20, 0, 0, 0, 0,  1, 0, 0, 0, 0, 32'h13);
    add(1, 32'h21, 0, 0, 0, 0,  1, 0, 0, 0, 0, 32'h13);
    add(1, 32'h22, 0, 0, 0, 0,  1, 0, 0, 0, 0, 32'h13);
    add(1, 32'h23, 1, 0, 0, 0,  1, 0, 1, 4, 0, 32'h13);
    add(1, 32'h30, 0, 0, 0, 0,  1, 0, 1, 4, 0, 32'h13);
    add(1, 32'h31, 0, 0, 0, 0,  1, 0, 1, 4, 0, 32'h13);
    add(1, 32'h32, 0, 0, 0, 0,  1, 0, 1, 4, 0, 32'h13);
    add(1, 32'h33, 1, 0, 0, 0,  0, 0, 1, 4, 0, 32'h13);
    add(1, 32'hEE, 1, 0, 0, 0,  0, 1, 1, 4, 0, 32'h13);
    add(0, 32'h00, 0, 0, 0, 1,  1, 1, 1, 4, 0, 32'h13);
    add(0, 32'h00, 0, 1, 0, 0,  1, 1, 1, 4, 1, 32'h30);
    add(0, 32'h00, 0, 1, 3, 0,  1, 1, 1, 4, 1, 32'h33);
    add(0, 32'h00, 0, 0, 0, 1,  1, 1, 0, 0, 0, 32'h33);
    // auto-commit on the DEPTH-th word, next write lands in the other bank
    add(1, 32'h50, 0, 0, 0, 0,  1, 1, 0, 0, 0, 32'h33);
    add(1, 32'h51, 0, 0, 0, 0,  1, 1, 0, 0, 0, 32'h33);
    add(1, 32'h52, 0, 0, 0, 0,  1, 1, 0, 0, 0, 32'h33);
    add(1, 32'h53, 0, 0, 0, 0,  1, 1, 0, 0, 0, 32'h33);
    add(1, 32'h54, 0, 0, 0, 0,  1, 1, 0, 0, 0, 32'h33);
    add(1, 32'h55, 0, 0, 0, 0,  1, 1, 0, 0, 0, 32'h33);
    add(1, 32'h56, 0, 0, 0, 0,  1, 1, 0, 0, 0, 32'h33);
    add(1, 32'h57, 0, 0, 0, 0,  1, 1, 1, 8, 0, 32'h33);
    add(1, 32'h60, 1, 0, 0, 0,  0, 1, 1, 8, 0, 32'h33);
    add(0, 32'h00, 0, 0, 0, 1,  1, 1, 1, 1, 0, 32'h33);
    add(0, 32'h00, 0, 1, 0, 0,  1, 1, 1, 1, 1, 32'h60);
    // short 2-word tile over stale bank0 contents, read past the end
    add(1, 32'h70, 0, 0, 0, 0,  1, 1, 1, 1, 0, 32'h60);
    add(1, 32'h71, 1, 0, 0, 0,  0, 1, 1, 1, 0, 32'h60);
    add(0, 32'h00, 0, 0, 0, 1,  1, 1, 1, 2, 0, 32'h60);
    add(0, 32'h00, 0, 1, 5, 0,  1, 1, 1, 2, 1, PAD_EXP);
    add(0, 32'h00, 0, 1, 1, 0,  1, 1, 1, 2, 1, 32'h71);
    add(0, 32'h00, 0, 0, 0, 1,  1, 1, 0, 0, 0, 32'h71);

    drive(0, 32'h0, 0, 0, 0, 0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk_all("reset", 1, 0, 0, 0, 0, 32'h0);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].wv, vq[i].wd, vq[i].wl, vq[i].re, vq[i].ra, vq[i].rr);
      step();
      chk_all($sformatf("v%0d", i + 1), vq[i].e_wrdy, vq[i].e_drop, vq[i].e_rrdy,
              vq[i].e_cnt, vq[i].e_rv, vq[i].e_rd);
    end

    // Mid-operation reset: 2 of 4 words written, read requested with rst
    drive(1, 32'hA1, 0, 0, 0, 0); step();
    drive(1, 32'hA2, 0, 0, 0, 0); step();
    drive(1, 32'hA3, 0, 1, 0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(0, 32'h0, 0, 0, 0, 0);
    chk_all("midrst", 1, 0, 0, 0, 0, 32'h0);

    // Fresh 1-word tile after reset
    drive(1, 32'h99, 1, 0, 0, 0); step();
    chk_all("tile1.commit", 1, 0, 1, 1, 0, 32'h0);
    drive(0, 32'h0, 0, 1, 0, 0); step();
    chk_all("tile1.read", 1, 0, 1, 1, 1, 32'h99);
    drive(0, 32'h0, 0, 0, 0, 0); step();
    chk("tile1.idle_rv", 32'(bus.rd_valid), 32'h0);
    chk("tile1.hold_rd", bus.rd_data, 32'h99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
